// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - borrow_in, LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to drive the signed-overflow flag; otherwise ovf is tied low.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q, bout_q;
  logic             d_bit, br_next, last_bit;

  // One full-subtractor slice on the current operand LSBs
  always_comb begin
    d_bit    = a_q[0] ^ b_q[0] ^ br_q;
    br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_RUN;
      S_RUN:   if (last_bit) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE:  in_ready  = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand shifters, result shifter, borrow flop and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      cnt_q  <= '0;
      br_q   <= 1'b0;
      bout_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            br_q  <= borrow_in;
            cnt_q <= '0;
          end
        end
        S_RUN: begin
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          diff_q <= {d_bit, diff_q[WIDTH-1:1]};
          br_q   <= br_next;
          cnt_q  <= cnt_q + CW'(1);
          if (last_bit) bout_q <= br_next;
        end
        default: ;
      endcase
    end
  end

  assign diff       = diff_q;
  assign borrow_out = bout_q;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q, b_msb_q, ovf_q;

  // Operand sign bits are kept aside because the shifters consume them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (state_q == S_IDLE && in_valid) begin
        a_msb_q <= a[WIDTH-1];
        b_msb_q <= b[WIDTH-1];
      end
      if (state_q == S_RUN && last_bit)
        ovf_q <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_bit);
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8); honours SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [7:0] a, b;
  logic       borrow_in;
  logic       out_valid, out_ready;
  logic [7:0] diff;
  logic       borrow_out, ovf;

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .borrow_in(borrow_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow_out(borrow_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

`ifdef SERIAL_SUB_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  // Drives one operation (accept at the edge after entry) and returns the observed result
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic bin,
                        output logic [7:0] d, output logic bo, output logic ov,
                        output int lat);
    @(negedge clk);
    a = av; b = bv; borrow_in = bin; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    d = diff; bo = borrow_out; ov = ovf;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_hs: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    n_checks++;
    if (diff !== 8'h00 || borrow_out !== 1'b0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL reset_data: diff=%h bo=%b ovf=%b, required 00 0 0", diff, borrow_out, ovf);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] d; logic bo, ov; int lat;
    run_op(8'h5A, 8'h23, 1'b0, d, bo, ov, lat);
    n_checks++;
    if (lat !== 8) begin n_fail++; $display("FAIL latency: got %0d edges, required 8", lat); end
    n_checks++;
    if (d !== 8'h37 || bo !== 1'b0 || ov !== 1'b0) begin
      n_fail++; $display("FAIL sub_5A_23: diff=%h bo=%b ovf=%b, required 37 0 0", d, bo, ov);
    end
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_op: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    run_op(8'h10, 8'h20, 1'b0, d, bo, ov, lat);
    n_checks++;
    if (d !== 8'hF0 || bo !== 1'b1 || ov !== 1'b0) begin
      n_fail++; $display("FAIL sub_10_20: diff=%h bo=%b ovf=%b, required F0 1 0", d, bo, ov);
    end
    run_op(8'h00, 8'h00, 1'b1, d, bo, ov, lat);
    n_checks++;
    if (d !== 8'hFF || bo !== 1'b1 || ov !== 1'b0) begin
      n_fail++; $display("FAIL sub_00_00_b1: diff=%h bo=%b ovf=%b, required FF 1 0", d, bo, ov);
    end
  endtask

  task automatic test_ovf();
    logic [7:0] d; logic bo, ov; int lat;
    run_op(8'h80, 8'h01, 1'b0, d, bo, ov, lat);
    n_checks++;
    if (d !== 8'h7F || bo !== 1'b0 || ov !== OVF_ON) begin
      n_fail++; $display("FAIL ovf_80_01: diff=%h bo=%b ovf=%b, required 7F 0 %b", d, bo, ov, OVF_ON);
    end
    run_op(8'h7F, 8'hFF, 1'b0, d, bo, ov, lat);
    n_checks++;
    if (d !== 8'h80 || bo !== 1'b1 || ov !== OVF_ON) begin
      n_fail++; $display("FAIL ovf_7F_FF: diff=%h bo=%b ovf=%b, required 80 1 %b", d, bo, ov, OVF_ON);
    end
    n_checks++;
    if (ovf !== OVF_ON) begin
      n_fail++; $display("FAIL ovf_hold: ovf=%b after handshake, required %b", ovf, OVF_ON);
    end
    run_op(8'h05, 8'h03, 1'b0, d, bo, ov, lat);
    n_checks++;
    if (d !== 8'h02 || bo !== 1'b0 || ov !== 1'b0) begin
      n_fail++; $display("FAIL ovf_05_03: diff=%h bo=%b ovf=%b, required 02 0 0", d, bo, ov);
    end
  endtask

  task automatic test_backpressure();
    int guard = 0;
    @(negedge clk);
    a = 8'h5A; b = 8'h23; borrow_in = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    while (!out_valid && guard < 40) begin
      @(posedge clk); guard++;
      @(negedge clk);
    end
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_timeout: out_valid=%b, required 1", out_valid); end
    a = 8'hFF; b = 8'h01; borrow_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== 8'h37 || borrow_out !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: ov=%b ir=%b diff=%h bo=%b, required 1 0 37 0",
                 i, out_valid, in_ready, diff, borrow_out);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 8'h37) begin
      n_fail++; $display("FAIL bp_release: ir=%b ov=%b diff=%h, required 1 0 37", in_ready, out_valid, diff);
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] d; logic bo, ov; int lat;
    @(negedge clk);
    a = 8'hFF; b = 8'h00; borrow_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || diff !== 8'h00 || in_ready !== 1'b1 || borrow_out !== 1'b0) begin
      n_fail++; $display("FAIL abort: ov=%b diff=%h ir=%b bo=%b, required 0 00 1 0",
                         out_valid, diff, in_ready, borrow_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_no_result: ov=%b ir=%b, required 0 1", out_valid, in_ready);
    end
    run_op(8'h01, 8'h01, 1'b0, d, bo, ov, lat);
    n_checks++;
    if (d !== 8'h00 || bo !== 1'b0) begin
      n_fail++; $display("FAIL post_abort: diff=%h bo=%b, required 00 0", d, bo);
    end
  endtask

  task automatic test_back_to_back();
    int acc_cyc[2];
    int hs_cyc[2];
    logic [7:0] rd[2];
    logic rb[2];
    int n_acc = 0, n_hs = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 60 && n_hs < 2; i++) begin
      @(negedge clk);
      if (n_acc == 0) begin a = 8'h5A; b = 8'h23; borrow_in = 1'b0; end
      else begin a = 8'h10; b = 8'h20; borrow_in = 1'b0; end
      in_valid = (n_acc < 2);
      #1;
      if (in_valid && in_ready) begin acc_cyc[n_acc] = i; n_acc++; end
      if (out_valid) begin hs_cyc[n_hs] = i; rd[n_hs] = diff; rb[n_hs] = borrow_out; n_hs++; end
      if (n_hs == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (n_hs != 2) begin
      n_fail++; $display("FAIL b2b_timeout: %0d results, required 2", n_hs);
    end else begin
      n_checks++;
      if (rd[0] !== 8'h37 || rb[0] !== 1'b0) begin
        n_fail++; $display("FAIL b2b_first: diff=%h bo=%b, required 37 0", rd[0], rb[0]);
      end
      n_checks++;
      if (rd[1] !== 8'hF0 || rb[1] !== 1'b1) begin
        n_fail++; $display("FAIL b2b_second: diff=%h bo=%b, required F0 1", rd[1], rb[1]);
      end
      n_checks++;
      if (acc_cyc[1] !== hs_cyc[0] + 1) begin
        n_fail++; $display("FAIL b2b_reaccept: accept at %0d, required %0d", acc_cyc[1], hs_cyc[0] + 1);
      end
      n_checks++;
      if (hs_cyc[0] - acc_cyc[0] !== 9) begin
        n_fail++; $display("FAIL b2b_spacing: handshake %0d cycles after accept, required 9",
                           hs_cyc[0] - acc_cyc[0]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 8'h00; b = 8'h00; borrow_in = 1'b0;
    test_reset();
    test_basic();
    test_ovf();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor computing diff = a - b - borrow_in, one bit per clock, LSB first, through a single borrow flop. It is the inverse-operation companion to the team's ripple full-adder datapath and is used where area matters more than latency. Operands enter through a valid/ready input handshake and results leave through a valid/ready output handshake.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock; single clock domain
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a, b, borrow_in are valid
in_ready  output  1  block can accept operands (IDLE only)
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
borrow_in  input  1  borrow into bit 0
out_valid  output  1  diff, borrow_out and ovf are valid
out_ready  input  1  consumer accepts the result
diff  output  WIDTH  a - b - borrow_in, modulo 2^WIDTH
borrow_out  output  1  borrow out of the MSB; 1 when unsigned a < b + borrow_in
ovf  output  1  signed overflow flag; see Optional Feature

Behaviour:
- Reset (async assert, sync release) values:
  - state = IDLE
  - in_ready = 1
  - out_valid = 0
  - diff = 0, borrow_out = 0, ovf = 0
  - internal shift registers, bit counter and borrow flop cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid & in_ready: capture a, b; load the borrow flop with borrow_in; clear the counter; go to RUN.
  - in_valid low: remain in IDLE.
- RUN:
  - in_ready = 0, out_valid = 0.
  - Each edge processes bit i = counter, with ai, bi the current LSBs of the operand shift registers and br the borrow flop:
    - d = ai ^ bi ^ br
    - br_next = (~ai & bi) | (~(ai ^ bi) & br)
  - d shifts into the MSB of the diff register; operand registers shift right; counter increments.
  - After the edge processing bit WIDTH-1, go to DONE.
  - Exactly WIDTH edges are spent in RUN.
- DONE:
  - out_valid = 1; diff holds the full result; borrow_out = final br.
  - Outputs stay stable while out_ready = 0.
  - On an edge with out_valid & out_ready: go to IDLE.
  - Outputs keep their last values after the handshake; out_valid drops.
- Latency: if the input handshake occurs at edge E0, out_valid is high from edge E0+WIDTH onward.
- Throughput: one result per WIDTH+2 cycles minimum.
  - No same-cycle re-accept: in_ready rises only in the cycle after the output handshake.
- in_valid asserted in RUN or DONE: ignored. Operands are not captured and nothing is queued.
- Input changes on a, b or borrow_in after capture have no effect on the result in flight.
- rst_n asserted mid-RUN or in DONE: the operation is aborted immediately and all outputs take their reset values; no partial result is ever presented.
- Counter width: clog2(WIDTH)+1 bits; there is no wrap-around within an operation.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - In DONE, ovf = (a[MSB] ^ b[MSB]) & (a[MSB] ^ diff[MSB]), computed from the captured operands.
  - ovf is valid only while out_valid = 1 and holds its value like diff.
  - Reset value is 0.
- Undefined:
  - The ovf port still exists and is tied to 0.
  - No MSB capture logic is synthesised.

Test Plan:
- WIDTH=8. Accept a=0x5A, b=0x23, borrow_in=0 -> out_valid exactly 8 edges after accept; diff=0x37, borrow_out=0.
- a=0x10, b=0x20, borrow_in=0 -> diff=0xF0, borrow_out=1; a=0x00, b=0x00, borrow_in=1 -> diff=0xFF, borrow_out=1.
- Back-pressure and ignored input:
  - Hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands -> diff, borrow_out and out_valid stable; in_ready=0; new operands are not captured.
  - Then set out_ready=1 -> IDLE next edge; in_ready=1.
- Reset abort: assert rst_n=0 after 3 RUN edges -> out_valid=0, diff=0, in_ready=1 immediately. After release, a=0x01, b=0x01 -> diff=0x00, borrow_out=0.
- SERIAL_SUB_OVF_EN defined:
  - 0x80-0x01 -> diff=0x7F, ovf=1
  - 0x7F-0xFF -> diff=0x80, ovf=1
  - 0x05-0x03 -> ovf=0.
- SERIAL_SUB_OVF_EN undefined: same vectors -> ovf=0 throughout.
- Back-to-back: two operand sets presented with in_valid held high and out_ready=1 -> both results correct; second accept occurs one cycle after the first output handshake.
